// File: rtl/trajectory_stepper.sv
// Ballistic trajectory integrator: latches launch direction/speed, then steps
// position under constant gravity in signed Q16.16 until landing or field exit.
module trajectory_stepper #(
    parameter int unsigned        STEP_DIV = 50000,
    parameter logic signed [31:0] GRAVITY  = 32'sh0000_4000,
    parameter logic signed [31:0] X0       = 32'sh0000_0000,
    parameter logic signed [31:0] Y0       = 32'sh000A_0000,
    parameter logic signed [31:0] X_MAX    = 32'sh00FF_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] sine_fixed,
    input  logic [31:0] cosine_fixed,
    input  logic [7:0]  speed,
    output logic [31:0] pos_x,
    output logic [31:0] pos_y,
    output logic        step_valid,
    output logic        busy,
    output logic        done,
    output logic        landed
);

    localparam int unsigned       CNT_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STEP_DIV - 1);
    localparam logic signed [40:0] P_MAX   = 41'sd2147483647;
    localparam logic signed [40:0] P_MIN   = -41'sd2147483648;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t                state_q, state_d;
    logic signed [31:0]    sin_q, cos_q;
    logic [7:0]            spd_q;
    logic signed [31:0]    vx_q, vy_q, x_q, y_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  step_valid_q, done_q, landed_q;

    logic signed [40:0]    prod_x, prod_y;
    logic signed [31:0]    x_step, y_step, vy_step;
    logic                  tick, hit_ground, out_field;

    function automatic logic signed [31:0] sat32(input logic signed [40:0] v);
        if (v > P_MAX) return 32'sh7FFF_FFFF;
        if (v < P_MIN) return 32'sh8000_0000;
        return v[31:0];
    endfunction

    // 33-bit add/sub; disagreeing top two bits flag overflow, clamp by true sign
    function automatic logic signed [31:0] sat_addsub(input logic signed [31:0] a,
                                                      input logic signed [31:0] b,
                                                      input logic sub);
        logic [32:0] s;
        s = sub ? ({a[31], a} - {b[31], b}) : ({a[31], a} + {b[31], b});
        if (s[32] != s[31]) return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        return s[31:0];
    endfunction

    always_comb begin
        prod_x     = $signed({33'd0, spd_q}) * $signed({{9{cos_q[31]}}, cos_q});
        prod_y     = $signed({33'd0, spd_q}) * $signed({{9{sin_q[31]}}, sin_q});
        x_step     = sat_addsub(x_q, vx_q, 1'b0);
        y_step     = sat_addsub(y_q, vy_q, 1'b0);
        vy_step    = sat_addsub(vy_q, GRAVITY, 1'b1);
        tick       = (state_q == S_RUN) && (cnt_q == CNT_LAST);
        hit_ground = y_step[31];
        out_field  = x_step > X_MAX;
    end

    always_ff @(posedge clock) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: if (start) state_d = S_LOAD;
            S_LOAD:         state_d = S_RUN;
            S_RUN:          if (tick && (hit_ground || out_field)) state_d = S_DONE;
            default:        state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_LOAD) || (state_q == S_RUN);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            sin_q        <= '0;
            cos_q        <= '0;
            spd_q        <= '0;
            vx_q         <= '0;
            vy_q         <= '0;
            x_q          <= X0;
            y_q          <= Y0;
            cnt_q        <= '0;
            step_valid_q <= 1'b0;
            done_q       <= 1'b0;
            landed_q     <= 1'b0;
        end else begin
            step_valid_q <= tick;
            done_q       <= tick && (hit_ground || out_field);
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        sin_q <= sine_fixed;
                        cos_q <= cosine_fixed;
                        spd_q <= speed;
                    end
                end
                S_LOAD: begin
                    vx_q     <= sat32(prod_x);
                    vy_q     <= sat32(prod_y);
                    x_q      <= X0;
                    y_q      <= Y0;
                    cnt_q    <= '0;
                    landed_q <= 1'b0;
                end
                S_RUN: begin
                    if (tick) begin
                        cnt_q <= '0;
                        x_q   <= x_step;
                        y_q   <= y_step;
                        vy_q  <= vy_step;
                        // ground takes precedence when both end conditions hit together
                        if (hit_ground || out_field) landed_q <= hit_ground;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign pos_x      = x_q;
    assign pos_y      = y_q;
    assign step_valid = step_valid_q;
    assign done       = done_q;
    assign landed     = landed_q;

endmodule

// File: tb/tb_trajectory_stepper.sv
// Self-checking bench for trajectory_stepper: spec-derived vector table, randomized
// shots against a step-by-step arithmetic model, plus reset-abort and held-start sequences.
module tb_trajectory_stepper;

    localparam int unsigned SD     = 4;
    localparam longint      X0_M   = 0;
    localparam longint      Y0_M   = 655360;
    localparam longint      XMAX_M = 16711680;
    localparam longint      G_M    = 16384;
    localparam longint      MAXV   = 64'sd2147483647;
    localparam longint      MINV   = -64'sd2147483648;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] sine_fixed = '0;
    logic [31:0] cosine_fixed = '0;
    logic [7:0]  speed = '0;
    logic [31:0] pos_x, pos_y;
    logic        step_valid, busy, done, landed;

    trajectory_stepper #(.STEP_DIV(SD)) dut (
        .clock(clock), .reset(reset), .start(start),
        .sine_fixed(sine_fixed), .cosine_fixed(cosine_fixed), .speed(speed),
        .pos_x(pos_x), .pos_y(pos_y), .step_valid(step_valid),
        .busy(busy), .done(done), .landed(landed)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Reference model: per-step trajectory from the launch rules, in plain 64-bit arithmetic
    longint mx[$];
    longint my[$];
    bit     mland;

    function automatic longint clamp32(input longint v);
        if (v > MAXV) return MAXV;
        if (v < MINV) return MINV;
        return v;
    endfunction

    task automatic model_shot(input logic [31:0] s, input logic [31:0] c, input logic [7:0] sp);
        longint vx, vy, x, y;
        mx.delete();
        my.delete();
        vx = clamp32(longint'(sp) * longint'($signed(c)));
        vy = clamp32(longint'(sp) * longint'($signed(s)));
        x = X0_M;
        y = Y0_M;
        mland = 1'b0;
        for (int n = 0; n < 100000; n++) begin
            x  = clamp32(x + vx);
            y  = clamp32(y + vy);
            vy = clamp32(vy - G_M);
            mx.push_back(x);
            my.push_back(y);
            if (y < 0) begin mland = 1'b1; break; end
            if (x > XMAX_M) begin mland = 1'b0; break; end
        end
    endtask

    task automatic run_shot(input string tag,
                            input logic [31:0] s, input logic [31:0] c, input logic [7:0] sp,
                            input bit hold,
                            input logic [31:0] s_nx, input logic [31:0] c_nx, input logic [7:0] sp_nx,
                            output int steps, output longint fx, output longint fy, output bit fl);
        int   idx;
        int   seen;
        bit   fin;
        logic exp_sv;
        model_shot(s, c, sp);
        sine_fixed   = s;
        cosine_fixed = c;
        speed        = sp;
        start        = 1'b1;
        @(negedge clock);
        chk({tag, " busy_in_load"}, longint'(busy), 1);
        if (!hold) start = 1'b0;
        sine_fixed   = s_nx;
        cosine_fixed = c_nx;
        speed        = sp_nx;
        idx = 0; seen = 0; fin = 1'b0;
        steps = 0; fx = 0; fy = 0; fl = 1'b0;
        while (!fin && idx < 20000) begin
            @(negedge clock);
            idx++;
            if (idx == 1) begin
                chk({tag, " load_pos_x"}, longint'($signed(pos_x)), X0_M);
                chk({tag, " load_pos_y"}, longint'($signed(pos_y)), Y0_M);
                chk({tag, " landed_cleared"}, longint'(landed), 0);
                chk({tag, " busy_run"}, longint'(busy), 1);
            end
            exp_sv = (idx > 1) && ((idx % SD) == 1) && (seen < mx.size());
            chk({tag, " step_valid"}, longint'(step_valid), longint'(exp_sv));
            if (step_valid && seen < mx.size()) begin
                chk({tag, " step_x"}, longint'($signed(pos_x)), mx[seen]);
                chk({tag, " step_y"}, longint'($signed(pos_y)), my[seen]);
                seen++;
                chk({tag, " done_with_step"}, longint'(done), longint'(seen == mx.size()));
                if (seen == mx.size()) begin
                    chk({tag, " landed"}, longint'(landed), longint'(mland));
                    fin = 1'b1;
                    fx  = longint'($signed(pos_x));
                    fy  = longint'($signed(pos_y));
                    fl  = landed;
                end
            end else begin
                chk({tag, " done_idle"}, longint'(done), 0);
            end
        end
        steps = seen;
        if (!fin) begin
            checks++;
            failures++;
            $display("FAIL %s timeout steps_seen=%0d expected_steps=%0d", tag, seen, mx.size());
        end else if (!hold) begin
            @(negedge clock);
            chk({tag, " busy_after_done"}, longint'(busy), 0);
            chk({tag, " done_one_clock"}, longint'(done), 0);
            chk({tag, " hold_x"}, longint'($signed(pos_x)), fx);
            chk({tag, " hold_y"}, longint'($signed(pos_y)), fy);
            chk({tag, " hold_landed"}, longint'(landed), longint'(fl));
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] s;
        logic [31:0] c;
        logic [7:0]  sp;
        int          n;
        longint      fx;
        longint      fy;
        bit          fl;
    } vec_t;

    vec_t tbl[7];

    initial begin
        int     steps;
        longint fx, fy;
        bit     fl;
        int     nsv;
        int     bad;
        int     rs, rc;

        tbl[0] = '{"horizontal", 32'h0000_0000, 32'h0001_0000, 8'd4,   10, 2621440,    -81920, 1'b1};
        tbl[1] = '{"straight_up", 32'h0001_0000, 32'h0000_0000, 8'd2,  21, 0,          -32768, 1'b1};
        tbl[2] = '{"out_of_field", 32'h0000_0000, 32'h0001_0000, 8'd255, 2, 33423360,  638976, 1'b0};
        tbl[3] = '{"speed_zero", 32'h0000_8000, 32'h0000_8000, 8'd0,   10, 0,          -81920, 1'b1};
        tbl[4] = '{"negative_vx", 32'h0000_0000, 32'hFFFF_0000, 8'd4,  10, -2621440,   -81920, 1'b1};
        tbl[5] = '{"sat_vx", 32'h0000_0000, 32'h7FFF_FFFF, 8'd255,      1, 2147483647, 655360, 1'b0};
        tbl[6] = '{"ground_wins", 32'hFFFF_F9FA, 32'h0001_0000, 8'd255, 2, 33423360,  -147444, 1'b1};

        repeat (3) @(negedge clock);
        chk("reset_pos_x", longint'($signed(pos_x)), X0_M);
        chk("reset_pos_y", longint'($signed(pos_y)), Y0_M);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_step_valid", longint'(step_valid), 0);
        chk("reset_landed", longint'(landed), 0);
        reset = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 7; i++) begin
            run_shot(tbl[i].name, tbl[i].s, tbl[i].c, tbl[i].sp, 1'b0,
                     $urandom, $urandom, 8'($urandom), steps, fx, fy, fl);
            chk({tbl[i].name, " steps"}, longint'(steps), longint'(tbl[i].n));
            chk({tbl[i].name, " final_x"}, fx, tbl[i].fx);
            chk({tbl[i].name, " final_y"}, fy, tbl[i].fy);
            chk({tbl[i].name, " final_landed"}, longint'(fl), longint'(tbl[i].fl));
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        for (int r = 0; r < 8; r++) begin
            rs = int'($urandom_range(0, 131072)) - 65536;
            rc = int'($urandom_range(0, 131072)) - 65536;
            run_shot("random", rs, rc, 8'($urandom_range(0, 40)), 1'b0,
                     $urandom, $urandom, 8'($urandom), steps, fx, fy, fl);
        end

        // Reset in the middle of a flight: abort with no done pulse, then relaunch
        sine_fixed = 32'h0; cosine_fixed = 32'h0001_0000; speed = 8'd4; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        nsv = 0; bad = 0;
        for (int k = 0; k < 200 && nsv < 3; k++) begin
            @(negedge clock);
            if (step_valid) nsv++;
            if (done) bad++;
        end
        chk("abort_three_steps_seen", longint'(nsv), 3);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        chk("abort_pos_x", longint'($signed(pos_x)), X0_M);
        chk("abort_pos_y", longint'($signed(pos_y)), Y0_M);
        chk("abort_busy", longint'(busy), 0);
        chk("abort_step_valid", longint'(step_valid), 0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done || busy) bad++;
        end
        chk("abort_no_done_no_busy", longint'(bad), 0);
        run_shot("relaunch", tbl[0].s, tbl[0].c, tbl[0].sp, 1'b0,
                 $urandom, $urandom, 8'($urandom), steps, fx, fy, fl);
        chk("relaunch steps", longint'(steps), longint'(tbl[0].n));
        chk("relaunch final_x", fx, tbl[0].fx);

        // start held through the flight; fresh inputs present at DONE relaunch at once
        run_shot("held_a", tbl[0].s, tbl[0].c, tbl[0].sp, 1'b1,
                 tbl[1].s, tbl[1].c, tbl[1].sp, steps, fx, fy, fl);
        chk("held_a steps", longint'(steps), longint'(tbl[0].n));
        chk("held_a final_y", fy, tbl[0].fy);
        run_shot("held_b", tbl[1].s, tbl[1].c, tbl[1].sp, 1'b0,
                 $urandom, $urandom, 8'($urandom), steps, fx, fy, fl);
        chk("held_b steps", longint'(steps), longint'(tbl[1].n));
        chk("held_b final_y", fy, tbl[1].fy);
        chk("held_b final_landed", longint'(fl), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
